sbuf_rd_wr_ctrl: RTL



---
 rtl/sbuf_rd_wr_ctrl_if.sv | 50 +++++
 rtl/sbuf_rd_wr_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/sbuf_rd_wr_ctrl_if.sv
// Bus bundle for the systolic-array buffer controller: host and result write
// ports, burst read control and stream, and the raw 1r1w buffer pins.
// slave = controller side, master = environment side (loaders, consumer, RAM).
interface sbuf_rd_wr_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 9
);
  logic          host_wvalid;
  logic          host_wready;
  logic [AW-1:0] host_wadr;
  logic [DW-1:0] host_wdata;
  logic          res_wvalid;
  logic          res_wready;
  logic [AW-1:0] res_wadr;
  logic [DW-1:0] res_wdata;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [LW-1:0] rd_len;
  logic          rd_busy;
  logic          rd_done;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;

  modport slave (
    input  host_wvalid, host_wadr, host_wdata,
    output host_wready,
    input  res_wvalid, res_wadr, res_wdata,
    output res_wready,
    input  rd_start, rd_base, rd_len, out_ready, ram_rdata,
    output rd_busy, rd_done, out_valid, out_data,
    output ram_radr, ram_wadr, ram_wdata, ram_wen
  );

  modport master (
    output host_wvalid, host_wadr, host_wdata,
    input  host_wready,
    output res_wvalid, res_wadr, res_wdata,
    input  res_wready,
    output rd_start, rd_base, rd_len, out_ready, ram_rdata,
    input  rd_busy, rd_done, out_valid, out_data,
    input  ram_radr, ram_wadr, ram_wdata, ram_wen
  );
endinterface

// File: rtl/sbuf_rd_wr_ctrl.sv
// Read/write controller for one 256x16 1r1w systolic-array buffer.
// Write port: fixed-priority mux, result writeback wins over host loader.
// Read side: burst sequencer streaming rd_len words from rd_base (address
// wraps modulo depth) with out_valid, rd_busy and a one-cycle rd_done.
// Optional macro SBUF_CTRL_BP_EN adds out_ready backpressure; when it is
// undefined out_ready is ignored and one word streams per cycle.
//
// state  | meaning
// IDLE   | no burst, waiting for rd_start
// STREAM | issuing read addresses, one per accepted transfer
// LAST   | final word displayed, waiting for it to be taken
module sbuf_rd_wr_ctrl #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 9
) (
  input logic             clk,
  input logic             rst,
  sbuf_rd_wr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STREAM, LAST} state_t;

  localparam logic [AW-1:0] ADR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] rd_cnt;
  logic          out_valid_q;
  logic          rd_done_q;
  logic          accept;
  logic          issue;

  assign bus.res_wready  = 1'b1;
  assign bus.host_wready = ~bus.res_wvalid;
  assign bus.ram_wen     = bus.res_wvalid | bus.host_wvalid;
  assign bus.ram_wadr    = bus.res_wvalid ? bus.res_wadr  : bus.host_wadr;
  assign bus.ram_wdata   = bus.res_wvalid ? bus.res_wdata : bus.host_wdata;

  assign bus.out_data  = bus.ram_rdata;
  assign bus.out_valid = out_valid_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.rd_busy   = (state != IDLE);

`ifdef SBUF_CTRL_BP_EN
  logic [AW-1:0] last_adr;

  // A transfer moves when nothing is displayed or the consumer takes it.
  assign accept = ~out_valid_q | bus.out_ready;
  assign issue  = (state == STREAM) && accept;
  // While stalled, re-read the displayed word so out_data stays put.
  assign bus.ram_radr = issue ? rd_ptr : last_adr;

  // Remember the address of the word currently on out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_adr <= '0;
    else if (issue) last_adr <= rd_ptr;
  end
`else
  logic unused_out_ready;

  assign unused_out_ready = bus.out_ready;
  assign accept = 1'b1;
  assign issue  = (state == STREAM);
  // rd_ptr has already advanced past the last issue outside STREAM.
  assign bus.ram_radr = (state == STREAM) ? rd_ptr : rd_ptr - ADR_ONE;
`endif

  // Burst sequencer: pointer/count, registered valid and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      rd_cnt      <= '0;
      out_valid_q <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_start) begin
            if (bus.rd_len == '0) begin
              rd_done_q <= 1'b1;
            end else begin
              rd_ptr <= bus.rd_base;
              rd_cnt <= bus.rd_len;
              state  <= STREAM;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            rd_ptr      <= rd_ptr + ADR_ONE;
            rd_cnt      <= rd_cnt - CNT_ONE;
            out_valid_q <= 1'b1;
            if (rd_cnt == CNT_ONE) state <= LAST;
          end
        end
        LAST: begin
          if (accept) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            rd_done_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
